// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU op codes and the operand bundle type
package alu_pkg;

    localparam int DATA_W = 16;
    // Wide enough for any register file the issue stage is built with (up to 256 entries).
    localparam int RD_W   = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_SUB  = 3'b100,
        OP_NAND = 3'b101,
        OP_NOR  = 3'b110,
        OP_XNOR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] in0;
        logic [DATA_W-1:0] in1;
        logic [RD_W-1:0]   rd;
    } operand_bundle_t;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with two bypassed read ports, r0 hardwired to zero
module alu_regfile #(
    parameter int  DATA_W = 16,
    parameter int  NREGS  = 8,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic [AW-1:0]     rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A write landing this cycle is visible to readers in the same cycle.
    always_comb begin
        rd_data0 = mem[rd_addr0];
        if (rd_addr0 == '0) begin
            rd_data0 = '0;
        end else if (wr_en && wr_addr == rd_addr0) begin
            rd_data0 = wr_data;
        end
    end

    always_comb begin
        rd_data1 = mem[rd_addr1];
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end else if (wr_en && wr_addr == rd_addr1) begin
            rd_data1 = wr_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ALU issue stage: operand read, hazard scoreboard, output register
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int  DATA_W = alu_pkg::DATA_W,
    parameter int  NREGS  = 8,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    output logic [AW-1:0]     alu_rd,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [NREGS-1:0]  pending_q;
    logic [NREGS-1:0]  pending_d;
    logic              valid_q;
    operand_bundle_t   bundle_q;
    operand_bundle_t   bundle_d;
    logic              src1_busy;
    logic              src2_busy;
    logic              rd_busy;
    logic              hazard;
    logic              accept;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr0 (in_rs1),
        .rd_data0 (rs1_data),
        .rd_addr1 (in_rs2),
        .rd_data1 (rs2_data),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

    // A register whose result is being written back this cycle no longer blocks.
    always_comb begin
        src1_busy = (in_rs1 != '0) && pending_q[in_rs1] && !(wb_en && wb_addr == in_rs1);
        src2_busy = (in_rs2 != '0) && pending_q[in_rs2] && !(wb_en && wb_addr == in_rs2);
        rd_busy   = (in_rd  != '0) && pending_q[in_rd]  && !(wb_en && wb_addr == in_rd);
        hazard    = src1_busy || (!in_use_imm && src2_busy) || rd_busy;
    end

    assign in_ready = (!valid_q || alu_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        bundle_d     = bundle_q;
        bundle_d.op  = in_op;
        bundle_d.in0 = rs1_data;
        bundle_d.in1 = in_use_imm ? in_imm : rs2_data;
        bundle_d.rd  = RD_W'(in_rd);
    end

    // Clear from writeback first so a same-cycle issue to that register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (accept && in_rd != '0) begin
            pending_d[in_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            bundle_q  <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (accept) begin
                valid_q  <= 1'b1;
                bundle_q <= bundle_d;
            end else if (alu_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign alu_valid = valid_q;
    assign alu_op    = bundle_q.op;
    assign alu_in0   = bundle_q.in0;
    assign alu_in1   = bundle_q.in1;
    assign alu_rd    = bundle_q.rd[AW-1:0];
    assign busy      = |pending_q;

    generate
        if (AW < RD_W) begin : g_rd_hi
            logic unused_rd_hi;
            assign unused_rd_hi = |bundle_q.rd[RD_W-1:AW];
        end
    endgenerate

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized and directed checks of alu_operand_stage against a reference model
module tb_alu_operand_stage;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          in_use_imm;
    logic [DW-1:0] in_imm;
    logic          alu_valid;
    logic          alu_ready;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_in0;
    logic [DW-1:0] alu_in1;
    logic [AW-1:0] alu_rd;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          busy;

    int total = 0;
    int bad   = 0;

    alu_operand_stage #(
        .DATA_W (DW),
        .NREGS  (NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_op     (alu_op),
        .alu_in0    (alu_in0),
        .alu_in1    (alu_in1),
        .alu_rd     (alu_rd),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural register values, outstanding destinations, the bundle the ALU sees.
    logic [DW-1:0] rf   [NR];
    bit            pend [NR];
    bit            m_valid;
    logic [2:0]    m_op;
    logic [DW-1:0] m_in0;
    logic [DW-1:0] m_in1;
    logic [AW-1:0] m_rd;
    bit            armed = 0;

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (wb_en && wb_addr == r) return wb_data;
        return rf[r];
    endfunction

    function automatic bit m_blocked(input logic [AW-1:0] r);
        return (r != 0) && pend[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic bit m_ready();
        bit src_hz;
        src_hz = m_blocked(in_rs1) || (!in_use_imm && m_blocked(in_rs2)) || m_blocked(in_rd);
        return (!m_valid || alu_ready) && !src_hz;
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < NR; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                rf[i]   = '0;
                pend[i] = 0;
            end
            m_valid = 0;
            m_op    = '0;
            m_in0   = '0;
            m_in1   = '0;
            m_rd    = '0;
            armed   = 1;
        end else begin
            acc = in_valid && m_ready();
            if (acc) begin
                m_op    = in_op;
                m_in0   = m_read(in_rs1);
                m_in1   = in_use_imm ? in_imm : m_read(in_rs2);
                m_rd    = in_rd;
                m_valid = 1;
            end else if (alu_ready) begin
                m_valid = 0;
            end
            if (wb_en) begin
                if (wb_addr != 0) rf[wb_addr] = wb_data;
                pend[wb_addr] = 0;
            end
            if (acc && in_rd != 0) pend[in_rd] = 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_alu_valid", alu_valid, m_valid);
            chk("m_busy", busy, m_busy());
            chk("m_in_ready", in_ready, m_ready());
            if (m_valid) begin
                chk("m_alu_op", alu_op, m_op);
                chk("m_alu_in0", alu_in0, m_in0);
                chk("m_alu_in1", alu_in1, m_in1);
                chk("m_alu_rd", alu_rd, m_rd);
            end
        end
    end

    task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic ui, input logic [DW-1:0] imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = ui;
        in_imm     = imm;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic ui, input logic [DW-1:0] imm);
        int n;
        set_req(op, rd, rs1, rs2, ui, imm);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_use_imm = 1'b0;
        in_imm     = '0;
        alu_ready  = 1'b1;
        wb_en      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_valid", alu_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_in0", alu_in0, 0);
        chk("rst_in1", alu_in1, 0);
        chk("rst_rd", alu_rd, 0);

        do_wb(3'd1, 16'h1234);
        do_wb(3'd2, 16'h0F0F);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, '0);
        chk("first_valid", alu_valid, 1);
        chk("first_in0", alu_in0, 16'h1234);
        chk("first_in1", alu_in1, 16'h0F0F);
        chk("first_rd", alu_rd, 3);
        chk("first_busy", busy, 1);

        set_req(OP_ADD, 3'd4, 3'd3, 3'd0, 1'b0, '0);
        @(negedge clk);
        chk("raw_stall", in_ready, 0);
        @(posedge clk);
        #1;
        wb_en   = 1'b1;
        wb_addr = 3'd3;
        wb_data = 16'h4143;
        @(negedge clk);
        chk("raw_release", in_ready, 1);
        @(posedge clk);
        #1;
        wb_en    = 1'b0;
        in_valid = 1'b0;
        chk("bypass_in0", alu_in0, 16'h4143);
        chk("bypass_rd", alu_rd, 4);

        alu_ready = 1'b0;
        set_req(OP_OR, 3'd5, 3'd1, 3'd2, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_ready", in_ready, 0);
            chk("hold_valid", alu_valid, 1);
            chk("hold_in0", alu_in0, 16'h4143);
            chk("hold_rd", alu_rd, 4);
            @(posedge clk);
            #1;
        end
        alu_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("nobubble_valid", alu_valid, 1);
        chk("nobubble_rd", alu_rd, 5);
        chk("nobubble_op", alu_op, 3'b010);
        chk("nobubble_in0", alu_in0, 16'h1234);
        chk("nobubble_in1", alu_in1, 16'h0F0F);

        set_req(OP_XOR, 3'd6, 3'd1, 3'd5, 1'b1, 16'hFFFF);
        @(negedge clk);
        chk("imm_no_stall", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("imm_in1", alu_in1, 16'hFFFF);
        chk("imm_op", alu_op, 3'b011);

        do_wb(3'd4, 16'h0004);
        do_wb(3'd5, 16'h0005);
        do_wb(3'd6, 16'h0006);
        chk("drained_busy", busy, 0);
        do_wb(3'd0, 16'hBEEF);
        issue(OP_AND, 3'd0, 3'd0, 3'd0, 1'b0, '0);
        chk("r0_in0", alu_in0, 0);
        chk("r0_in1", alu_in1, 0);
        chk("r0_busy", busy, 0);

        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b0, '0);
        issue(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b0, '0);
        alu_ready = 1'b0;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_valid", alu_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        alu_ready = 1'b1;
        chk("mid_rst_valid", alu_valid, 0);
        chk("mid_rst_busy", busy, 0);
        issue(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b0, '0);
        chk("r1_after_rst", alu_in0, 0);

        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 255) != 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_op      = 3'($urandom);
            in_rd      = AW'($urandom);
            in_rs1     = AW'($urandom);
            in_rs2     = AW'($urandom);
            in_use_imm = ($urandom_range(0, 3) == 0);
            in_imm     = DW'($urandom);
            alu_ready  = ($urandom_range(0, 3) != 0);
            wb_en      = ($urandom_range(0, 1) != 0);
            wb_addr    = AW'($urandom);
            wb_data    = DW'($urandom);
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        wb_en     = 1'b0;
        alu_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Issue stage directly upstream of the 16-bit ALU. It accepts operation requests (op, destination, two source register indices or an immediate) and reads an internal register file. It registers the op and both operands for the ALU behind a valid/ready handshake. It takes results back through a writeback port, forwards same-cycle writeback data, and stalls on read-after-write (RAW) and write-after-write (WAW) hazards using a per-register pending scoreboard.

Parameters:
DATA_W, 16, operand and register width (the ALU consumes 16).
NREGS, 8, register file depth; must be a power of two, at least 2.
AW, $clog2(NREGS), register index width (localparam, derived, not overridable).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted this cycle when in_valid && in_ready
in_op  in  3  ALU op code, passed through unchanged
in_rd  in  AW  destination register
in_rs1  in  AW  source 1 index -> alu_in0
in_rs2  in  AW  source 2 index -> alu_in1 when in_use_imm=0
in_use_imm  in  1  1: alu_in1 = in_imm
in_imm  in  DATA_W  immediate operand
alu_valid  out  1  operand bundle valid
alu_ready  in  1  ALU/downstream accepts bundle
alu_op  out  3  registered op
alu_in0  out  DATA_W  registered operand 0
alu_in1  out  DATA_W  registered operand 1
alu_rd  out  AW  registered destination tag
wb_en  in  1  writeback strobe
wb_addr  in  AW  writeback register
wb_data  in  DATA_W  writeback value
busy  out  1  OR of all scoreboard pending bits

Behaviour:
- Reset (rst_n=0 at a clock edge): every register-file entry is 0, all pending bits are 0, alu_valid=0, and alu_op/alu_in0/alu_in1/alu_rd are 0. A reset in mid-operation discards the held bundle and all pending state.
- r0 always reads 0. Writes to r0 are ignored. r0 is never marked pending.
- Operand read is combinational from the register file. If wb_en && wb_addr==rsX && rsX!=0 in the same cycle, the read returns wb_data (bypass).
- hazard = src1_busy || (!in_use_imm && src2_busy) || rd_busy.
  - srcX_busy = pending[rsX] && !(wb_en && wb_addr==rsX).
  - rd_busy is defined the same way on in_rd.
  - Index 0 never causes a hazard.
- in_ready = (!alu_valid || alu_ready) && !hazard. in_ready may depend combinationally on the in_* fields.
- On accept (edge N): alu_op/in0/in1/rd are loaded with the bypassed operands, and alu_valid=1 after edge N. Latency is 1 cycle.
- Scoreboard update on accept: pending[in_rd] is set (unless in_rd=0).
- Output hold: while alu_valid && !alu_ready, all alu_* outputs stay stable.
- When alu_ready=1 and there is no new accept, alu_valid clears on the next edge.
- Back-to-back operation: accept and drain in the same cycle sustains one request per cycle.
- Writeback: on wb_en, regfile[wb_addr] <= wb_data and pending[wb_addr] is cleared.
- Simultaneous wb_en clear and accept set on the same register: the set wins, so the bit stays pending.
- Writeback to a register that is not pending still writes the data; this is not an error.
- busy is registered-state derived (no combinational path from the inputs).

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and op code constants: ADD=000, AND=001, OR=010, XOR=011, SUB=100, NAND=101, NOR=110, XNOR=111.
  - An operand-bundle struct: op, in0, in1, rd.
- One sub-module: alu_regfile. It has NREGS x DATA_W storage, two combinational read ports with write bypass, one synchronous write port, and r0 hardwired to zero.
- The scoreboard and handshake stay in the top level.

Test Plan:
- Reset, then write r1=0x1234 and r2=0x0F0F via wb, then issue op=000 rd=3 rs1=1 rs2=2 -> one cycle later alu_valid=1, alu_in0=0x1234, alu_in1=0x0F0F, alu_rd=3, busy=1.
- Issue rd=3, then issue rs1=3 before writeback -> in_ready=0. Assert wb_en wb_addr=3 wb_data=0x4143 -> in_ready=1 that same cycle and alu_in0=0x4143.
- Hold alu_ready=0 for 3 cycles with alu_valid=1 -> outputs unchanged and in_ready=0. Raise alu_ready with a new request pending -> the new bundle is loaded the next cycle with no bubble.
- Issue in_use_imm=1, in_imm=0xFFFF, rs2=5 with pending[5]=1 -> no stall, alu_in1=0xFFFF.
- Write wb r0=0xBEEF, then read rs1=0 -> alu_in0=0x0000. Issue rd=0 -> busy stays 0.
- Apply rst_n=0 for one cycle while alu_valid=1 and pending={1,3} -> alu_valid=0, busy=0, and r1 reads 0 afterwards.
